// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared constants and check-state type for the tracer stages
//
// Purpose : common definitions used by the tracer injection and checking stages.
// Contents: TRACER_COUNT, TRACER_IDX_W, check_state_e, sat_inc32().
package sensor_pkg;

   localparam int TRACER_COUNT = 8;
   localparam int TRACER_IDX_W = $clog2(TRACER_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ALIGN   = 2'd1,
      ACQUIRE = 2'd2,
      TRACK   = 2'd3
   } check_state_e;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sensor_tracer_check_if.sv
// rtl/sensor_tracer_check_if.sv - tapped sensor-frame stream bundle
//
// Purpose : groups the tapped AXI-Stream signals of the sensor-frame path.
// Signals : tdata (DW), tvalid, tready. A beat is tvalid & tready.
// Modports: master drives all three, slave observes all three.
interface sensor_tracer_check_if #(
   parameter int DW = 512
) ();

   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;

   modport master (output tdata, output tvalid, output tready);
   modport slave  (input  tdata, input  tvalid, input  tready);

endinterface

// File: rtl/tracer_cell_table.sv
// rtl/tracer_cell_table.sv - 8x32 tracer cell register file with position decode
//
// Purpose : stores the byte offset of each tracer cell within a frame and
//           splits every offset into beat number and byte lane.
// Ports   : clk, resetn          clock, async active-low reset
//           tracer_index_i       entry selected for write and read
//           wr_cell_i/wr_strobe_i  write data / write enable
//           rd_cell_o            combinational read of the selected entry
//           cycle_o[i]           beat number of tracer i (cell / bytes-per-beat)
//           offset_o[i]          byte lane of tracer i (cell % bytes-per-beat)
module tracer_cell_table
   import sensor_pkg::*;
#(
   parameter  int DW    = 512,
   localparam int BW    = $clog2(DW/8),
   localparam int CYC_W = 32 - BW
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [TRACER_IDX_W-1:0] tracer_index_i,
   input  logic [31:0]             wr_cell_i,
   input  logic                    wr_strobe_i,
   output logic [31:0]             rd_cell_o,
   output logic [CYC_W-1:0]        cycle_o  [TRACER_COUNT],
   output logic [BW-1:0]           offset_o [TRACER_COUNT]
);

   logic [31:0] cell_q [TRACER_COUNT];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < TRACER_COUNT; i++) cell_q[i] <= '0;
      end else if (wr_strobe_i) begin
         cell_q[tracer_index_i] <= wr_cell_i;
      end
   end

   assign rd_cell_o = cell_q[tracer_index_i];

   always_comb begin
      for (int i = 0; i < TRACER_COUNT; i++) begin
         cycle_o[i]  = cell_q[i][31:BW];
         offset_o[i] = cell_q[i][BW-1:0];
      end
   end

endmodule

// File: rtl/sensor_tracer_check.sv
// rtl/sensor_tracer_check.sv - tracer consistency/sequence monitor on the sensor-frame stream
//
// Purpose : watches the tapped stream, extracts the enabled tracer bytes of
//           every frame, flags frames whose tracers disagree and (with
//           TRACER_CHECK_SEQ_EN defined) frames whose tracer value does not
//           follow the previous frame's value by +1 mod 256. Never drives the stream.
// Ports   : clk, resetn                 clock, async active-low reset
//           axis_in (slave)             tapped tdata/tvalid/tready
//           frame_size                  frame size in bytes (multiple of DW/8)
//           tracer_enable               per-tracer check enable
//           tracer_index, wr_tracer_cell, wr_tracer_cell_wstrobe, rd_tracer_cell
//                                       tracer cell table access
//           check_enable, clear         level enable / one-cycle statistics clear
//           frame_count, error_count, last_value, first_error_frame,
//           first_error_valid, error_pulse   registered frame statistics
// Config  : `define TRACER_CHECK_SEQ_EN adds the inter-frame sequence check in TRACK.
module sensor_tracer_check
   import sensor_pkg::*;
#(
   parameter int DW = 512
) (
   input  logic                clk,
   input  logic                resetn,
   sensor_tracer_check_if.slave axis_in,
   input  logic [31:0]         frame_size,
   input  logic [7:0]          tracer_enable,
   input  logic [2:0]          tracer_index,
   input  logic [31:0]         wr_tracer_cell,
   input  logic                wr_tracer_cell_wstrobe,
   output logic [31:0]         rd_tracer_cell,
   input  logic                check_enable,
   input  logic                clear,
   output logic [31:0]         frame_count,
   output logic [31:0]         error_count,
   output logic [7:0]          last_value,
   output logic [31:0]         first_error_frame,
   output logic                first_error_valid,
   output logic                error_pulse
);

   localparam int BW    = $clog2(DW/8);
   localparam int CYC_W = 32 - BW;
   localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

   logic [CYC_W-1:0] tr_cycle  [TRACER_COUNT];
   logic [BW-1:0]    tr_offset [TRACER_COUNT];

   tracer_cell_table #(.DW(DW)) u_cell_table (
      .clk            (clk),
      .resetn         (resetn),
      .tracer_index_i (tracer_index),
      .wr_cell_i      (wr_tracer_cell),
      .wr_strobe_i    (wr_tracer_cell_wstrobe),
      .rd_cell_o      (rd_tracer_cell),
      .cycle_o        (tr_cycle),
      .offset_o       (tr_offset)
   );

   // Byte-lane bits of frame_size are zero by construction.
   logic unused_frame_size_lsbs;
   assign unused_frame_size_lsbs = ^frame_size[BW-1:0];

   logic             beat;
   logic [CYC_W-1:0] cycles_per_frame;
   logic [CYC_W-1:0] frame_cycle_q;
   logic             first_beat;
   logic             last_beat;

   assign beat             = axis_in.tvalid & axis_in.tready;
   assign cycles_per_frame = frame_size[31:BW];
   assign first_beat       = (frame_cycle_q == '0);
   assign last_beat        = (frame_cycle_q == cycles_per_frame - CYC_ONE);

   // Free-running beat position; runs in every state so ALIGN can find frame starts.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   frame_cycle_q <= '0;
      else if (beat) frame_cycle_q <= last_beat ? '0 : frame_cycle_q + CYC_ONE;
   end

   // ---------------- check FSM ----------------
   check_state_e state_q, state_d;
   logic         chk_beat;
   logic         frame_done;
   logic         in_track;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear || !check_enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ALIGN;
            // A single-beat frame completes on its own start beat.
            ALIGN:   if (beat && first_beat) state_d = last_beat ? TRACK : ACQUIRE;
            ACQUIRE: if (beat && last_beat) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      chk_beat = 1'b0;
      in_track = 1'b0;
      case (state_q)
         ALIGN:   chk_beat = beat && first_beat;
         ACQUIRE: chk_beat = beat;
         TRACK:   begin chk_beat = beat; in_track = 1'b1; end
         default: chk_beat = 1'b0;
      endcase
      // clear or a dropped enable discards the beat, including a frame's last one.
      chk_beat   = chk_beat && check_enable && !clear;
      frame_done = chk_beat && last_beat;
   end

   // ---------------- per-frame tracer extraction ----------------
   logic [7:0] ref_q, ref_d;
   logic       ref_found_q, ref_found_d;
   logic       cons_err_q, cons_err_d;

   always_comb begin
      logic       hit;
      logic [7:0] byte_v;
      // Frame start reseeds the accumulators, so no explicit per-frame reset is needed.
      ref_found_d = first_beat ? 1'b0 : ref_found_q;
      ref_d       = first_beat ? 8'h00 : ref_q;
      cons_err_d  = first_beat ? 1'b0 : cons_err_q;
      for (int i = 0; i < TRACER_COUNT; i++) begin
         hit    = tracer_enable[i] && (tr_cycle[i] < cycles_per_frame) &&
                  (tr_cycle[i] == frame_cycle_q);
         byte_v = axis_in.tdata[{tr_offset[i], 3'b000} +: 8];
         if (hit) begin
            if (!ref_found_d) begin
               ref_found_d = 1'b1;
               ref_d       = byte_v;
            end else if (byte_v != ref_d) begin
               cons_err_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ref_q       <= '0;
         ref_found_q <= 1'b0;
         cons_err_q  <= 1'b0;
      end else if (chk_beat) begin
         ref_q       <= ref_d;
         ref_found_q <= ref_found_d;
         cons_err_q  <= cons_err_d;
      end
   end

   // ---------------- frame verdict and statistics ----------------
   logic [31:0] frame_count_q, error_count_q, first_error_frame_q;
   logic [7:0]  last_value_q;
   logic        first_error_valid_q, error_pulse_q;
   logic        seq_err;
   logic        frame_fail;

`ifdef TRACER_CHECK_SEQ_EN
   // A frame without any tracer carries no value, so it cannot break the sequence.
   assign seq_err = in_track && ref_found_d && (ref_d != last_value_q + 8'd1);
`else
   logic unused_in_track;
   assign unused_in_track = in_track;
   assign seq_err         = 1'b0;
`endif

   assign frame_fail = cons_err_d || seq_err;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_count_q       <= '0;
         error_count_q       <= '0;
         first_error_frame_q <= '0;
         last_value_q        <= '0;
         first_error_valid_q <= 1'b0;
         error_pulse_q       <= 1'b0;
      end else if (clear) begin
         frame_count_q       <= '0;
         error_count_q       <= '0;
         first_error_frame_q <= '0;
         last_value_q        <= '0;
         first_error_valid_q <= 1'b0;
         error_pulse_q       <= 1'b0;
      end else begin
         error_pulse_q <= 1'b0;
         if (frame_done) begin
            frame_count_q <= sat_inc32(frame_count_q);
            if (ref_found_d) last_value_q <= ref_d;
            if (frame_fail) begin
               error_count_q <= sat_inc32(error_count_q);
               error_pulse_q <= 1'b1;
               if (!first_error_valid_q) begin
                  first_error_frame_q <= frame_count_q;
                  first_error_valid_q <= 1'b1;
               end
            end
         end
      end
   end

   assign frame_count       = frame_count_q;
   assign error_count       = error_count_q;
   assign last_value        = last_value_q;
   assign first_error_frame = first_error_frame_q;
   assign first_error_valid = first_error_valid_q;
   assign error_pulse       = error_pulse_q;

endmodule

// File: tb/tb_sensor_tracer_check.sv
// tb/tb_sensor_tracer_check.sv - self-checking bench for sensor_tracer_check
module tb_sensor_tracer_check;

   localparam int DW  = 512;
   localparam int BPB = DW/8;
   localparam int CPF = 4;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   sensor_tracer_check_if #(.DW(DW)) axis_if ();

   logic [31:0] frame_size;
   logic [7:0]  tracer_enable;
   logic [2:0]  tracer_index;
   logic [31:0] wr_tracer_cell;
   logic        wr_tracer_cell_wstrobe;
   logic [31:0] rd_tracer_cell;
   logic        check_enable;
   logic        clear;
   logic [31:0] frame_count;
   logic [31:0] error_count;
   logic [7:0]  last_value;
   logic [31:0] first_error_frame;
   logic        first_error_valid;
   logic        error_pulse;

   sensor_tracer_check #(.DW(DW)) dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .axis_in                (axis_if),
      .frame_size             (frame_size),
      .tracer_enable          (tracer_enable),
      .tracer_index           (tracer_index),
      .wr_tracer_cell         (wr_tracer_cell),
      .wr_tracer_cell_wstrobe (wr_tracer_cell_wstrobe),
      .rd_tracer_cell         (rd_tracer_cell),
      .check_enable           (check_enable),
      .clear                  (clear),
      .frame_count            (frame_count),
      .error_count            (error_count),
      .last_value             (last_value),
      .first_error_frame      (first_error_frame),
      .first_error_valid      (first_error_valid),
      .error_pulse            (error_pulse)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   int          m_fc;
   bit          m_active, m_acq, m_ep;
   logic [7:0]  m_seen [$];
   logic [31:0] m_fcnt, m_ecnt, m_fef;
   logic        m_fev, m_pulse;
   logic [7:0]  m_last;
   logic [31:0] m_cells [8];
   logic [7:0]  fb [256];

   task automatic model_reset();
      m_fc = 0; m_active = 0; m_acq = 0; m_ep = 0;
      m_seen.delete();
      m_fcnt = 0; m_ecnt = 0; m_fef = 0; m_fev = 0; m_pulse = 0; m_last = 0;
      for (int i = 0; i < 8; i++) m_cells[i] = 0;
   endtask

   task automatic finish_frame();
      bit fail = 0;
      foreach (m_seen[k]) if (m_seen[k] != m_seen[0]) fail = 1;
`ifdef TRACER_CHECK_SEQ_EN
      if (m_acq && m_seen.size() > 0 && m_seen[0] != 8'(m_last + 8'd1)) fail = 1;
`endif
      if (m_seen.size() > 0) m_last = m_seen[0];
      if (fail) begin
         if (!m_fev) begin m_fef = m_fcnt; m_fev = 1; end
         m_ecnt++;
         m_pulse = 1;
      end
      m_fcnt++;
      m_acq    = 1;
      m_active = 0;
   endtask

   // Applies the rules to the inputs that were present at the last rising edge.
   task automatic model_update();
      bit ec, bt;
      int lane;
      if (!resetn) begin model_reset(); return; end
      ec = check_enable && !clear;
      bt = axis_if.tvalid && axis_if.tready;
      m_pulse = 0;
      if (clear) begin
         m_fcnt = 0; m_ecnt = 0; m_fef = 0; m_fev = 0; m_last = 0;
      end
      if (!ec) begin m_active = 0; m_acq = 0; end
      if (bt) begin
         if (m_fc == 0) begin
            m_active = ec && m_ep;
            m_seen.delete();
         end
         if (m_active) begin
            for (int i = 0; i < 8; i++) begin
               if (tracer_enable[i] && (m_cells[i] / BPB) == m_fc && (m_cells[i] / BPB) < CPF) begin
                  lane = int'(m_cells[i] % BPB);
                  m_seen.push_back(axis_if.tdata[lane*8 +: 8]);
               end
            end
            if (m_fc == CPF-1) finish_frame();
         end
         m_fc = (m_fc + 1) % CPF;
      end
      if (wr_tracer_cell_wstrobe) m_cells[tracer_index] = wr_tracer_cell;
      m_ep = ec;
   endtask

   task automatic check_all();
      check_eq("frame_count",       frame_count,       m_fcnt);
      check_eq("error_count",       error_count,       m_ecnt);
      check_eq("last_value",        last_value,        m_last);
      check_eq("first_error_frame", first_error_frame, m_fef);
      check_eq("first_error_valid", first_error_valid, m_fev);
      check_eq("error_pulse",       error_pulse,       m_pulse);
      check_eq("rd_tracer_cell",    rd_tracer_cell,    m_cells[tracer_index]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_update();
      check_all();
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DW-1:0] beat_data(input int b);
      logic [DW-1:0] d;
      for (int j = 0; j < BPB; j++) d[j*8 +: 8] = fb[b*BPB + j];
      return d;
   endfunction

   task automatic make_frame(input logic [7:0] v0, input logic [7:0] v1);
      for (int j = 0; j < 256; j++) fb[j] = 8'($urandom_range(255));
      fb[5]   = v0;
      fb[130] = v1;
      fb[200] = v1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         axis_if.tvalid = 1'b0;
         axis_if.tready = 1'($urandom_range(1));
         axis_if.tdata  = rand_data();
         step();
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input int stall_pct);
      int n = 0;
      while ($urandom_range(99) < stall_pct && n < 20) begin
         case ($urandom_range(2))
            0:       begin axis_if.tvalid = 1'b0; axis_if.tready = 1'b0; end
            1:       begin axis_if.tvalid = 1'b1; axis_if.tready = 1'b0; end
            default: begin axis_if.tvalid = 1'b0; axis_if.tready = 1'b1; end
         endcase
         axis_if.tdata = rand_data();
         step();
         n++;
      end
      axis_if.tvalid = 1'b1;
      axis_if.tready = 1'b1;
      axis_if.tdata  = d;
      step();
      axis_if.tvalid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] v0, input logic [7:0] v1, input int stall_pct);
      make_frame(v0, v1);
      for (int b = 0; b < CPF; b++) send_beat(beat_data(b), stall_pct);
   endtask

   task automatic write_cell(input logic [2:0] idx, input logic [31:0] val);
      axis_if.tvalid         = 1'b0;
      tracer_index           = idx;
      wr_tracer_cell         = val;
      wr_tracer_cell_wstrobe = 1'b1;
      step();
      wr_tracer_cell_wstrobe = 1'b0;
   endtask

   task automatic pulse_clear();
      axis_if.tvalid = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      logic [7:0] v, nv, v1;
      int pick;
      resetn = 1'b0;
      axis_if.tdata = '0; axis_if.tvalid = 1'b0; axis_if.tready = 1'b0;
      frame_size = 32'd256; tracer_enable = 8'h00; tracer_index = 3'd0;
      wr_tracer_cell = '0; wr_tracer_cell_wstrobe = 1'b0;
      check_enable = 1'b0; clear = 1'b0;
      step();
      step();
      check_eq("rst_frame_count", frame_count, 32'd0);
      check_eq("rst_error_count", error_count, 32'd0);
      check_eq("rst_last_value", last_value, 32'd0);
      check_eq("rst_first_error_valid", first_error_valid, 32'd0);
      check_eq("rst_error_pulse", error_pulse, 32'd0);
      check_eq("rst_cell", rd_tracer_cell, 32'd0);
      resetn = 1'b1;
      step();

      write_cell(3'd0, 32'd5);
      write_cell(3'd1, 32'd130);
      tracer_enable = 8'h03;
      check_eq("cell1_readback", rd_tracer_cell, 32'd130);

      // Enable together with the first beat: that frame is missed, the next two checked.
      check_enable = 1'b1;
      send_frame(8'h10, 8'h10, 0);
      send_frame(8'h11, 8'h11, 0);
      send_frame(8'h12, 8'h12, 0);
      check_eq("s1_frame_count", frame_count, 32'd2);
      check_eq("s1_error_count", error_count, 32'd0);
      check_eq("s1_last_value", last_value, 32'h12);
      idle(2);

      // Inconsistent tracers in one frame.
      pulse_clear();
      idle(2);
      send_frame(8'h20, 8'h21, 0);
      check_eq("s2_error_pulse", error_pulse, 32'd1);
      check_eq("s2_error_count", error_count, 32'd1);
      check_eq("s2_first_error_valid", first_error_valid, 32'd1);
      check_eq("s2_first_error_frame", first_error_frame, 32'd0);
      idle(1);
      check_eq("s2_pulse_one_cycle", error_pulse, 32'd0);

      // Sequence with 0xFF->0x00 wrap and a skip.
      pulse_clear();
      idle(2);
      send_frame(8'hFE, 8'hFE, 0);
      send_frame(8'hFF, 8'hFF, 0);
      send_frame(8'h00, 8'h00, 0);
      send_frame(8'h02, 8'h02, 0);
      check_eq("s3_frame_count", frame_count, 32'd4);
      check_eq("s3_last_value", last_value, 32'h02);
`ifdef TRACER_CHECK_SEQ_EN
      check_eq("s3_error_count", error_count, 32'd1);
      check_eq("s3_first_error_frame", first_error_frame, 32'd3);
`else
      check_eq("s3_error_count", error_count, 32'd0);
`endif
      idle(2);

      // Enable raised at frame_cycle 2, with random stalls.
      check_enable = 1'b0;
      pulse_clear();
      idle(2);
      make_frame(8'h2F, 8'h55);
      send_beat(beat_data(0), 30);
      send_beat(beat_data(1), 30);
      check_enable = 1'b1;
      send_beat(beat_data(2), 0);
      send_beat(beat_data(3), 30);
      send_frame(8'h30, 8'h30, 30);
      send_frame(8'h31, 8'h31, 30);
      send_frame(8'h32, 8'h32, 30);
      check_eq("s4_frame_count", frame_count, 32'd3);
      check_eq("s4_error_count", error_count, 32'd0);
      check_eq("s4_last_value", last_value, 32'h32);

      // clear on a last beat discards that frame.
      send_frame(8'h33, 8'h33, 0);
      send_frame(8'h34, 8'h99, 0);
      check_eq("s5_pre_error_count", error_count, 32'd1);
      make_frame(8'h35, 8'h35);
      for (int b = 0; b < CPF-1; b++) send_beat(beat_data(b), 0);
      clear = 1'b1;
      send_beat(beat_data(CPF-1), 0);
      clear = 1'b0;
      check_eq("s5_frame_count", frame_count, 32'd0);
      check_eq("s5_error_count", error_count, 32'd0);
      check_eq("s5_first_error_valid", first_error_valid, 32'd0);
      check_eq("s5_last_value", last_value, 32'd0);
      idle(2);
      send_frame(8'h50, 8'h50, 0);
      check_eq("s5_after_frame_count", frame_count, 32'd1);

      // Tracer 1 moved beyond the frame.
      write_cell(3'd1, 32'd300);
      check_eq("s6_cell1_readback", rd_tracer_cell, 32'd300);
      pulse_clear();
      idle(2);
      for (int f = 0; f < 3; f++) send_frame(8'(8'h40 + f), 8'(8'h40 + f) ^ 8'h5A, 10);
      check_eq("s6_frame_count", frame_count, 32'd3);
      check_eq("s6_error_count", error_count, 32'd0);
      check_eq("s6_last_value", last_value, 32'h42);

      // Randomized run against the model.
      write_cell(3'd1, 32'd130);
      pulse_clear();
      idle(2);
      v = 8'h60;
      for (int f = 0; f < 150; f++) begin
         tracer_enable = 8'($urandom_range(3));
         check_enable  = ($urandom_range(29) != 0);
         nv = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'(v + 8'd1);
         v1 = ($urandom_range(9) == 0) ? (nv ^ 8'h01) : nv;
         make_frame(nv, v1);
         for (int b = 0; b < CPF; b++) begin
            if ($urandom_range(19) == 0) begin
               pick = $urandom_range(2);
               write_cell(3'd1, (pick == 0) ? 32'd130 : (pick == 1) ? 32'd200 : 32'd300);
            end
            if ($urandom_range(49) == 0) clear = 1'b1;
            send_beat(beat_data(b), 25);
            clear = 1'b0;
         end
         v = nv;
      end
      check_enable = 1'b1;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
